rival_spawn_scheduler: RTL and testbench
========================================

Name: rival_spawn_scheduler

Overview:
- Controller that owns the rival-car slot pool for the road display.
- Decides when and where rival cars spawn, using the 8-bit LFSR value for lane choice, and advances them down the road on a divided movement tick.
- Retires cars that leave the road, counts passes, and detects collision with the player car.
- Drives the packed rival position/active buses read by the sprite renderer, plus the game run/crash state.

Parameters:
- NUM_SLOTS, 4, number of concurrent rival cars.
- TICK_DIV, 500000, clk cycles per movement tick.
- SPAWN_GAP, 40, movement ticks between spawn attempts.
- ROAD_X, 200, left edge of the road in pixels.
- TOP_Y, 150, spawn row and top of the road.
- BOTTOM_Y, 390, retire row.
- CAR_W, 14, car width in pixels; used for both player and rival.
- CAR_H, 16, car height in pixels; used for both player and rival.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse: begin or restart a run
- random_num  in  8  LFSR output, sampled at spawn
- player_x  in  10  player car left x
- player_y  in  10  player car top y
- rival_x_bus  out  10*NUM_SLOTS  slot i x at bits [10i+9:10i]
- rival_y_bus  out  10*NUM_SLOTS  slot i y, same packing
- rival_active  out  NUM_SLOTS  slot occupied
- collide  out  1  high in CRASH state
- running  out  1  high in RUN state
- tick  out  1  one-cycle movement tick strobe
- pass_count  out  16  cars retired this run, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All rival_active, x, y, pass_count, tick divider and spawn counter are 0.
  - collide=0, running=0.
  - Reset mid-run is taken on the same edge and discards all pending updates.
- Tick divider counts 0..TICK_DIV-1 and free-runs in every state. tick=1 for the single cycle the count equals TICK_DIV-1.
- FSM states: IDLE, RUN, CRASH.
  - IDLE: slots empty, no movement. start -> RUN next cycle; spawn counter=0, pass_count=0.
  - RUN: running=1. Processes ticks as below. Collision -> CRASH.
  - CRASH: collide=1. Positions, active flags and pass_count are frozen; ticks are ignored. start -> clears all slots and counters and enters RUN in one cycle.
- Movement, on a tick in RUN: every active slot gets y <= y+1.
  - If the new y >= BOTTOM_Y, the slot is cleared (active=0) and pass_count increments (saturating).
  - Multiple retirements on the same tick add their combined count.
- Spawn counter:
  - Increments on each RUN tick and saturates at SPAWN_GAP-1.
  - On a tick where the counter equals SPAWN_GAP-1: allocate the lowest-index slot that is free, using the free mask sampled before this tick's retirements. Set x = ROAD_X+8+random_num[6:0] (range 208..335), y = TOP_Y, active=1, then reset the counter to 0.
  - If no slot is free, the counter holds and the spawn is retried on every following tick.
  - A spawned car is not moved on its spawn tick.
- Collision:
  - Registered AABB test of the player box against each active slot box. Boxes overlap iff px < rx+CAR_W, rx < px+CAR_W, py < ry+CAR_H and ry < py+CAR_H.
  - Evaluated every cycle in RUN. On overlap, the state is CRASH on the next edge (collide high 1 cycle after overlap first exists on inputs/registers).
  - If collision and a tick occur in the same cycle, the collision wins and that tick's movement, spawn and retire are discarded.
- start while in RUN is ignored.
- All arithmetic is 10-bit unsigned; y never wraps because retirement happens at BOTTOM_Y < 1024.

Optional Feature:
- Macro: RIVAL_SPEEDUP_EN.
- When defined:
  - A 2-bit speed register, reset to 0 and cleared on start.
  - Step per tick = speed+1.
  - speed increments, saturating at 3, each time pass_count crosses a multiple of 16.
  - Retirement still uses y >= BOTTOM_Y after the step.
- When undefined: step is fixed at 1 and no speed register exists.

Test Plan (bench uses TICK_DIV=4, SPAWN_GAP=2):
- Reset then start, random_num=8'h05 -> on the 2nd tick slot0 active with x=213, y=150; other slots inactive.
- Keep running with player at (0,0) -> slot0 y increments by 1 per tick. On the tick where y reaches 390, slot0 clears and pass_count=1.
- Fill all 4 slots; spawn counter at SPAWN_GAP-1 -> no 5th spawn; the held counter spawns on the tick after slot0 retires, into slot0.
- Player at (213,160) with slot0 at x=213 moving down -> collide=1 and running=0 one cycle after first overlap; further ticks leave positions unchanged.
- In CRASH pulse start -> next cycle running=1, all rival_active=0, pass_count=0.
- Assert rst_n=0 mid-RUN on a tick cycle -> next edge all outputs zero and state=IDLE; no spawn or move is committed.

Source files
------------

// File: rtl/rival_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rival_spawn_scheduler
// Purpose  : Owns the rival-car slot pool for the road display. Spawns rivals
//            into free slots using the LFSR for lane choice, advances them on
//            a divided movement tick, retires cars leaving the road, counts
//            passes and detects collision with the player car.
// Options  : RIVAL_SPEEDUP_EN - when defined, rivals step speed+1 rows per
//            tick; speed rises (max 3) every 16 passes.
// Revision : 1.0 - initial release
// ============================================================================
module rival_spawn_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int TICK_DIV  = 500000,
    parameter int SPAWN_GAP = 40,
    parameter int ROAD_X    = 200,
    parameter int TOP_Y     = 150,
    parameter int BOTTOM_Y  = 390,
    parameter int CAR_W     = 14,
    parameter int CAR_H     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               random_num,
    input  logic [9:0]               player_x,
    input  logic [9:0]               player_y,
    output logic [10*NUM_SLOTS-1:0]  rival_x_bus,
    output logic [10*NUM_SLOTS-1:0]  rival_y_bus,
    output logic [NUM_SLOTS-1:0]     rival_active,
    output logic                     collide,
    output logic                     running,
    output logic                     tick,
    output logic [15:0]              pass_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TICK_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int c_GAP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_MAX  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_MAX   = c_GAP_W'(SPAWN_GAP - 1);
    localparam logic [9:0]          c_SPAWN_X0  = 10'(ROAD_X + 8);
    localparam logic [9:0]          c_TOP_Y     = 10'(TOP_Y);
    localparam logic [9:0]          c_BOTTOM_Y  = 10'(BOTTOM_Y);
    localparam logic [9:0]          c_CAR_W     = 10'(CAR_W);
    localparam logic [9:0]          c_CAR_H     = 10'(CAR_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t                         state_q,     state_d;
    logic [c_TICK_W-1:0]            tick_cnt_q,  tick_cnt_d;
    logic [c_GAP_W-1:0]             spawn_cnt_q, spawn_cnt_d;
    logic [NUM_SLOTS-1:0][9:0]      x_q,         x_d;
    logic [NUM_SLOTS-1:0][9:0]      y_q,         y_d;
    logic [NUM_SLOTS-1:0]           active_q,    active_d;
    logic [15:0]                    pass_q,      pass_d;
    logic                           running_q,   running_d;
    logic                           collide_q,   collide_d;
`ifdef RIVAL_SPEEDUP_EN
    logic [1:0]                     speed_q,     speed_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                           w_tick;
    logic [9:0]                     w_step;
    logic [9:0]                     w_spawn_x;
    logic [NUM_SLOTS-1:0][9:0]      w_ystep;
    logic [NUM_SLOTS-1:0]           w_retire;
    logic [NUM_SLOTS-1:0]           w_overlap;
    logic                           w_hit;
    logic [NUM_SLOTS-1:0]           w_free_oh;
    logic                           w_any_free;
    logic                           w_spawn_due;
    logic [15:0]                    w_pass_sat;
    logic                           w_unused_rnd;

    assign w_tick      = (tick_cnt_q == c_TICK_MAX);
    assign w_spawn_x   = c_SPAWN_X0 + {3'b000, random_num[6:0]};
    assign w_hit       = |w_overlap;
    assign w_any_free  = ~&active_q;
    assign w_spawn_due = (spawn_cnt_q == c_GAP_MAX);
    // Bit 7 of the LFSR is not needed for the 128-pixel lane window.
    assign w_unused_rnd = random_num[7];

`ifdef RIVAL_SPEEDUP_EN
    assign w_step = {8'b0, speed_q} + 10'd1;
`else
    assign w_step = 10'd1;
`endif

    // Per-slot stepped position, retirement and player overlap
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            assign w_ystep[i]   = y_q[i] + w_step;
            assign w_retire[i]  = active_q[i] && (w_ystep[i] >= c_BOTTOM_Y);
            assign w_overlap[i] = active_q[i]
                               && (player_x < x_q[i] + c_CAR_W)
                               && (x_q[i] < player_x + c_CAR_W)
                               && (player_y < y_q[i] + c_CAR_H)
                               && (y_q[i] < player_y + c_CAR_H);
        end
    endgenerate

    // Lowest-index free slot, taken from the pre-retirement occupancy
    always_comb begin
        logic found;
        found     = 1'b0;
        w_free_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active_q[i] && !found) begin
                w_free_oh[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Pass counter plus this tick's retirements, saturating at 16'hFFFF
    always_comb begin
        logic [16:0] acc;
        acc = {1'b0, pass_q};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_retire[i]) begin
                acc = acc + 17'd1;
            end
        end
        w_pass_sat = acc[16] ? 16'hFFFF : acc[15:0];
    end

    // Next-state: run control, movement, spawning, retirement and collision
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = w_tick ? '0 : tick_cnt_q + 1'b1;
        spawn_cnt_d = spawn_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        active_d    = active_q;
        pass_d      = pass_q;
        running_d   = running_q;
        collide_d   = collide_q;
`ifdef RIVAL_SPEEDUP_EN
        speed_d     = speed_q;
`endif

        if (start && (state_q != ST_RUN)) begin
            // Begin or restart a run from an empty road
            state_d     = ST_RUN;
            spawn_cnt_d = '0;
            x_d         = '0;
            y_d         = '0;
            active_d    = '0;
            pass_d      = '0;
            running_d   = 1'b1;
            collide_d   = 1'b0;
`ifdef RIVAL_SPEEDUP_EN
            speed_d     = 2'd0;
`endif
        end else if (state_q == ST_RUN) begin
            if (w_hit) begin
                // Collision beats a coincident tick: nothing moves this cycle
                state_d   = ST_CRASH;
                running_d = 1'b0;
                collide_d = 1'b1;
            end else if (w_tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (active_q[i]) begin
                        if (w_retire[i]) begin
                            active_d[i] = 1'b0;
                            x_d[i]      = '0;
                            y_d[i]      = '0;
                        end else begin
                            y_d[i]      = w_ystep[i];
                        end
                    end else if (w_spawn_due && w_free_oh[i]) begin
                        // Fresh car sits at the top row until the next tick
                        active_d[i] = 1'b1;
                        x_d[i]      = w_spawn_x;
                        y_d[i]      = c_TOP_Y;
                    end
                end

                if (w_spawn_due) begin
                    // A full pool holds the counter so the spawn retries
                    if (w_any_free) begin
                        spawn_cnt_d = '0;
                    end
                end else begin
                    spawn_cnt_d = spawn_cnt_q + 1'b1;
                end

                pass_d = w_pass_sat;
`ifdef RIVAL_SPEEDUP_EN
                if ((w_pass_sat[15:4] != pass_q[15:4]) && (speed_q != 2'd3)) begin
                    speed_d = speed_q + 2'd1;
                end
`endif
            end
        end else if (state_q != ST_CRASH && state_q != ST_IDLE) begin
            // Recover from an unreachable encoding
            state_d = ST_IDLE;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            spawn_cnt_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            active_q    <= '0;
            pass_q      <= '0;
            running_q   <= 1'b0;
            collide_q   <= 1'b0;
`ifdef RIVAL_SPEEDUP_EN
            speed_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            spawn_cnt_q <= spawn_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            active_q    <= active_d;
            pass_q      <= pass_d;
            running_q   <= running_d;
            collide_q   <= collide_d;
`ifdef RIVAL_SPEEDUP_EN
            speed_q     <= speed_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rival_x_bus  = x_q;
    assign rival_y_bus  = y_q;
    assign rival_active = active_q;
    assign collide      = collide_q;
    assign running      = running_q;
    assign tick         = w_tick;
    assign pass_count   = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_rival_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rival_spawn_scheduler
// Purpose  : Directed self-checking bench for rival_spawn_scheduler with
//            TICK_DIV=4 and SPAWN_GAP=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rival_spawn_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  random_num;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [39:0] rival_x_bus;
    logic [39:0] rival_y_bus;
    logic [3:0]  rival_active;
    logic        collide;
    logic        running;
    logic        tick;
    logic [15:0] pass_count;

    int n_total = 0;
    int n_pass  = 0;

    rival_spawn_scheduler #(
        .NUM_SLOTS (4),
        .TICK_DIV  (4),
        .SPAWN_GAP (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .random_num   (random_num),
        .player_x     (player_x),
        .player_y     (player_y),
        .rival_x_bus  (rival_x_bus),
        .rival_y_bus  (rival_y_bus),
        .rival_active (rival_active),
        .collide      (collide),
        .running      (running),
        .tick         (tick),
        .pass_count   (pass_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          adv;     // ticks to advance before checking
        logic [7:0]  rnd;     // random_num applied during the advance
        logic [3:0]  e_act;
        logic        chk0;    // compare slot0 position
        logic [9:0]  e_x0;
        logic [9:0]  e_y0;
        logic        chk1;    // compare slot1 y
        logic [9:0]  e_y1;
        logic [15:0] e_pass;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until just past the next tick edge (bounded)
    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (tick !== 1'b1) begin
            n_total++;
            $display("FAIL wait_tick: tick=%0b after %0d cycles, required 1", tick, n);
        end
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // slot0 spawns on tick 2, then one car per 2 ticks until the pool is full
        vecs[0] = '{1,   8'h05, 4'b0000, 1'b0, 10'd0,   10'd0,   1'b0, 10'd0,   16'd0};
        vecs[1] = '{1,   8'h05, 4'b0001, 1'b1, 10'd213, 10'd150, 1'b0, 10'd0,   16'd0};
        vecs[2] = '{1,   8'h05, 4'b0001, 1'b1, 10'd213, 10'd151, 1'b0, 10'd0,   16'd0};
        vecs[3] = '{1,   8'h05, 4'b0011, 1'b1, 10'd213, 10'd152, 1'b1, 10'd150, 16'd0};
        vecs[4] = '{4,   8'h05, 4'b1111, 1'b1, 10'd213, 10'd156, 1'b1, 10'd154, 16'd0};
        vecs[5] = '{2,   8'h05, 4'b1111, 1'b1, 10'd213, 10'd158, 1'b1, 10'd156, 16'd0};
        vecs[6] = '{231, 8'h05, 4'b1111, 1'b1, 10'd213, 10'd389, 1'b1, 10'd387, 16'd0};
        vecs[7] = '{1,   8'h05, 4'b1110, 1'b0, 10'd0,   10'd0,   1'b1, 10'd388, 16'd1};
        vecs[8] = '{1,   8'hFF, 4'b1111, 1'b1, 10'd335, 10'd150, 1'b1, 10'd389, 16'd1};
        vecs[9] = '{1,   8'hFF, 4'b1101, 1'b1, 10'd335, 10'd151, 1'b0, 10'd0,   16'd2};

        rst_n      = 1'b0;
        start      = 1'b0;
        random_num = 8'h05;
        player_x   = 10'd0;
        player_y   = 10'd0;
        repeat (3) step();

        // Reset state
        chk("reset active",  rival_active, 40'd0);
        chk("reset x_bus",   rival_x_bus,  40'd0);
        chk("reset y_bus",   rival_y_bus,  40'd0);
        chk("reset pass",    pass_count,   40'd0);
        chk("reset running", running,      40'd0);
        chk("reset collide", collide,      40'd0);

        rst_n = 1'b1;
        step();
        chk("idle running", running, 40'd0);
        pulse_start();
        chk("start running", running, 40'd1);

        // Spawn / move / retire table
        for (int k = 0; k < 10; k++) begin
            random_num = vecs[k].rnd;
            for (int t = 0; t < vecs[k].adv; t++) wait_tick();
            chk($sformatf("vec%0d active", k), rival_active, 40'(vecs[k].e_act));
            chk($sformatf("vec%0d pass", k),   pass_count,   40'(vecs[k].e_pass));
            chk($sformatf("vec%0d running", k), running,     40'd1);
            if (vecs[k].chk0) begin
                chk($sformatf("vec%0d x0", k), rival_x_bus[9:0], 40'(vecs[k].e_x0));
                chk($sformatf("vec%0d y0", k), rival_y_bus[9:0], 40'(vecs[k].e_y0));
            end
            if (vecs[k].chk1) begin
                chk($sformatf("vec%0d y1", k), rival_y_bus[19:10], 40'(vecs[k].e_y1));
            end
        end

        // Collision with slot0 at (335,151); crash freezes the road
        player_x = 10'd335;
        player_y = 10'd160;
        step();
        chk("crash collide", collide, 40'd1);
        chk("crash running", running, 40'd0);
        wait_tick();
        wait_tick();
        chk("frozen active", rival_active,      40'd13);
        chk("frozen y0",     rival_y_bus[9:0],  40'd151);
        chk("frozen pass",   pass_count,        40'd2);
        chk("frozen collide", collide,          40'd1);

        // Restart from CRASH
        player_x   = 10'd213;
        player_y   = 10'd160;
        random_num = 8'h05;
        pulse_start();
        chk("restart running", running,      40'd1);
        chk("restart collide", collide,      40'd0);
        chk("restart active",  rival_active, 40'd0);
        chk("restart pass",    pass_count,   40'd0);

        // Spawn lands on the player: crash exactly one cycle later
        wait_tick();
        chk("run2 tick1 active", rival_active, 40'd0);
        wait_tick();
        chk("run2 spawn active",  rival_active,     40'd1);
        chk("run2 spawn y0",      rival_y_bus[9:0], 40'd150);
        chk("run2 pre collide",   collide,          40'd0);
        step();
        chk("run2 collide",       collide, 40'd1);
        chk("run2 running",       running, 40'd0);

        // Reset asserted on a tick cycle mid-run
        player_x = 10'd0;
        player_y = 10'd0;
        pulse_start();
        wait_tick();
        wait_tick();
        chk("run3 active", rival_active, 40'd1);
        begin
            int n;
            n = 0;
            while (tick !== 1'b1 && n < 16) begin
                step();
                n++;
            end
        end
        chk("pre reset tick", tick, 40'd1);
        rst_n = 1'b0;
        step();
        chk("midreset active",  rival_active, 40'd0);
        chk("midreset x_bus",   rival_x_bus,  40'd0);
        chk("midreset y_bus",   rival_y_bus,  40'd0);
        chk("midreset pass",    pass_count,   40'd0);
        chk("midreset running", running,      40'd0);
        chk("midreset collide", collide,      40'd0);
        rst_n = 1'b1;
        wait_tick();
        wait_tick();
        chk("idle no spawn", rival_active, 40'd0);
        chk("idle running",  running,      40'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
